clk_divide_multi: RTL and testbench

- Parametrised successor to the fixed divide-by-4 clock divider.
- Generates NUM_CH independent, phase-aligned divided clocks from one master clock, each with a runtime-programmable even divide ratio.
- Supports glitch-free reconfiguration through a load/busy handshake.
- Sits at the top level of the processor wrapper and feeds the processor, regfile, imem and dmem clock domains.

---
 rtl/clkdiv_pkg.sv | 15 +
 rtl/clkdiv_channel.sv | 67 ++++++
 rtl/clk_divide_multi.sv | 104 ++++++++++
 tb/tb_clk_divide_multi.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the multi-channel even clock divider.
package clkdiv_pkg;

    localparam int DEF_CNT_W = 4;
    localparam int DEF_CODE  = 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_RESTART = 2'd2
    } state_t;

    typedef logic [DEF_CNT_W-1:0] code_t;

endpackage

// File: rtl/clkdiv_channel.sv
// One divided-clock channel: half-period counter, toggle flop, tick and park detect.
// Optional output inversion when CLKDIV_INVERT_EN is defined.
module clkdiv_channel #(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             drain,
    input  logic             restart,
    input  logic [CNT_W-1:0] code,
`ifdef CLKDIV_INVERT_EN
    input  logic             invert,
    input  logic             restart_invert,
`endif
    output logic             clk,
    output logic             tick,
    output logic             parked
);

    logic [CNT_W-1:0] cnt_reg;
    logic             clk_reg;
    logic             tick_reg;
    logic             phase;
    logic             at_end;

    // The flop holds the visible output; phase is the un-inverted divider state.
`ifdef CLKDIV_INVERT_EN
    assign phase = clk_reg ^ invert;
`else
    assign phase = clk_reg;
`endif

    assign at_end = (cnt_reg == code);
    assign parked = drain & ~phase & at_end;
    assign clk    = clk_reg;
    assign tick   = tick_reg & enable;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_reg  <= '0;
            clk_reg  <= 1'b0;
            tick_reg <= 1'b0;
        end else if (!enable) begin
            tick_reg <= 1'b0;
        end else if (restart) begin
            cnt_reg  <= '0;
`ifdef CLKDIV_INVERT_EN
            clk_reg  <= restart_invert;
            tick_reg <= restart_invert & ~clk_reg;
`else
            clk_reg  <= 1'b0;
            tick_reg <= 1'b0;
`endif
        end else if (parked) begin
            tick_reg <= 1'b0;
        end else if (at_end) begin
            cnt_reg  <= '0;
            clk_reg  <= ~clk_reg;
            tick_reg <= ~clk_reg;
        end else begin
            cnt_reg  <= cnt_reg + CNT_W'(1);
            tick_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_divide_multi.sv
// NUM_CH phase-aligned even clock dividers with glitch-free load/drain/restart reconfiguration.
// Define CLKDIV_INVERT_EN to add per-channel output inversion (cfg_invert).
module clk_divide_multi
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DEFAULT_CODE = DEF_CODE
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [NUM_CH*CNT_W-1:0] cfg_code,
    input  logic                    cfg_load,
`ifdef CLKDIV_INVERT_EN
    input  logic [NUM_CH-1:0]       cfg_invert,
`endif
    output logic                    cfg_busy,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick
);

    localparam logic [CNT_W-1:0] RST_CODE = CNT_W'(DEFAULT_CODE);

    state_t                  state_reg;
    logic [NUM_CH*CNT_W-1:0] shadow_code_reg;
    logic [NUM_CH*CNT_W-1:0] active_code_reg;
    logic [NUM_CH-1:0]       parked;
    logic                    drain;
    logic                    restart;
`ifdef CLKDIV_INVERT_EN
    logic [NUM_CH-1:0]       shadow_inv_reg;
    logic [NUM_CH-1:0]       active_inv_reg;
`endif

    assign drain   = (state_reg == ST_DRAIN);
    assign restart = (state_reg == ST_RESTART);

    // Loads are only taken in RUN, so a pending shadow value is never overwritten.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_RUN;
            cfg_busy        <= 1'b0;
            shadow_code_reg <= {NUM_CH{RST_CODE}};
            active_code_reg <= {NUM_CH{RST_CODE}};
`ifdef CLKDIV_INVERT_EN
            shadow_inv_reg  <= '0;
            active_inv_reg  <= '0;
`endif
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (cfg_load) begin
                        shadow_code_reg <= cfg_code;
`ifdef CLKDIV_INVERT_EN
                        shadow_inv_reg  <= cfg_invert;
`endif
                        cfg_busy        <= 1'b1;
                        state_reg       <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (enable && (&parked)) begin
                        state_reg <= ST_RESTART;
                    end
                end
                ST_RESTART: begin
                    if (enable) begin
                        active_code_reg <= shadow_code_reg;
`ifdef CLKDIV_INVERT_EN
                        active_inv_reg  <= shadow_inv_reg;
`endif
                        cfg_busy        <= 1'b0;
                        state_reg       <= ST_RUN;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            clkdiv_channel #(
                .CNT_W(CNT_W)
            ) u_ch (
                .clock          (clock),
                .reset          (reset),
                .enable         (enable),
                .drain          (drain),
                .restart        (restart),
                .code           (active_code_reg[gi*CNT_W +: CNT_W]),
`ifdef CLKDIV_INVERT_EN
                .invert         (active_inv_reg[gi]),
                .restart_invert (shadow_inv_reg[gi]),
`endif
                .clk            (clk_out[gi]),
                .tick           (tick[gi]),
                .parked         (parked[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_divide_multi.sv
// Bench for clk_divide_multi: vector table, directed corner sequences, random run vs reference model.
module tb_clk_divide_multi;

    localparam int NCH = 4;
    localparam int CW  = 4;
    localparam int W   = NCH * CW;

    logic           clock;
    logic           reset;
    logic           enable;
    logic [W-1:0]   cfg_code;
    logic           cfg_load;
    logic           cfg_busy;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
`ifdef CLKDIV_INVERT_EN
    logic [NCH-1:0] cfg_invert;
    initial cfg_invert = '0;
`endif

    int total = 0;
    int bad   = 0;

    clk_divide_multi #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_CODE(1)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .cfg_code (cfg_code),
        .cfg_load (cfg_load),
`ifdef CLKDIV_INVERT_EN
        .cfg_invert(cfg_invert),
`endif
        .cfg_busy (cfg_busy),
        .clk_out  (clk_out),
        .tick     (tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: each channel counts down the edges left until its next toggle.
    int m_code[NCH], m_shadow[NCH], m_rem[NCH];
    bit m_lvl[NCH], m_rose[NCH];
    int m_mode;     // 0 running, 1 draining, 2 restarting
    bit m_busy;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_code[i] = 1; m_shadow[i] = 1; m_rem[i] = 2;
                m_lvl[i] = 0; m_rose[i] = 0;
            end
            m_mode = 0;
            m_busy = 0;
        end else begin
            int  nm;
            bit  allp;
            bit  p;
            nm = m_mode;
            for (int i = 0; i < NCH; i++) m_rose[i] = 0;
            if (m_mode == 0 && cfg_load) begin
                for (int i = 0; i < NCH; i++) m_shadow[i] = int'(cfg_code[i*CW +: CW]);
                m_busy = 1;
                nm = 1;
            end
            if (enable) begin
                if (m_mode == 2) begin
                    for (int i = 0; i < NCH; i++) begin
                        m_code[i] = m_shadow[i];
                        m_rem[i]  = m_code[i] + 1;
                        m_lvl[i]  = 0;
                    end
                    m_busy = 0;
                    nm = 0;
                end else begin
                    allp = 1;
                    for (int i = 0; i < NCH; i++) begin
                        p = (m_mode == 1) && !m_lvl[i] && (m_rem[i] == 1);
                        allp = allp & p;
                        if (!p) begin
                            m_rem[i] = m_rem[i] - 1;
                            if (m_rem[i] == 0) begin
                                m_lvl[i]  = !m_lvl[i];
                                m_rem[i]  = m_code[i] + 1;
                                m_rose[i] = m_lvl[i];
                            end
                        end
                    end
                    if (m_mode == 1 && allp) nm = 2;
                end
            end
            m_mode = nm;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock edge with the given inputs, then compare all outputs to the model.
    task automatic cycle(input bit en, input bit ld, input logic [W-1:0] code);
        logic [NCH-1:0] e_clk;
        logic [NCH-1:0] e_tick;
        enable   = en;
        cfg_load = ld;
        cfg_code = code;
        @(posedge clock);
        @(negedge clock);
        for (int i = 0; i < NCH; i++) begin
            e_clk[i]  = m_lvl[i];
            e_tick[i] = m_rose[i] & enable;
        end
        chk("model", 64'({tick, cfg_busy, clk_out}), 64'({e_tick, m_busy, e_clk}));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("async_reset", 64'({tick, cfg_busy, clk_out}), 64'(0));
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic measure_period(input int ch, output int p);
        int t1;
        t1 = -1;
        p  = -1;
        for (int k = 0; k < 100; k++) begin
            cycle(1'b1, 1'b0, '0);
            if (tick[ch]) begin
                if (t1 < 0) t1 = k;
                else begin
                    p = k - t1;
                    return;
                end
            end
        end
    endtask

    typedef struct {
        bit             en;
        bit             ld;
        logic [W-1:0]   code;
        logic [NCH-1:0] clk;
        bit             busy;
        logic [NCH-1:0] tk;
    } vec_t;

    vec_t tbl[17];

    initial begin
        int p;
        int hi;
        int n;
        bit en;
        bit ld;
        logic [W-1:0] rc;

        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 1'b0, 4'b1111};
        tbl[2]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 1'b0, 4'b0000};
        tbl[3]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'b0000};
        tbl[4]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'b0000};
        tbl[5]  = '{1'b1, 1'b0, 16'h0000, 4'b1111, 1'b0, 4'b1111};
        tbl[6]  = '{1'b1, 1'b1, 16'h7310, 4'b1111, 1'b1, 4'b0000};
        tbl[7]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 1'b1, 4'b0000};
        tbl[8]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 1'b1, 4'b0000};
        tbl[9]  = '{1'b1, 1'b0, 16'h0000, 4'b0000, 1'b1, 4'b0000};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 4'b0000};
        tbl[11] = '{1'b1, 1'b0, 16'h0000, 4'b0001, 1'b0, 4'b0001};
        tbl[12] = '{1'b1, 1'b0, 16'h0000, 4'b0010, 1'b0, 4'b0010};
        tbl[13] = '{1'b1, 1'b0, 16'h0000, 4'b0011, 1'b0, 4'b0001};
        tbl[14] = '{1'b1, 1'b0, 16'h0000, 4'b0100, 1'b0, 4'b0100};
        tbl[15] = '{1'b1, 1'b0, 16'h0000, 4'b0101, 1'b0, 4'b0001};
        tbl[16] = '{1'b1, 1'b0, 16'h0000, 4'b0110, 1'b0, 4'b0010};

        reset    = 1'b1;
        enable   = 1'b0;
        cfg_load = 1'b0;
        cfg_code = '0;
        #2 reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_state", 64'({tick, cfg_busy, clk_out}), 64'(0));
        reset = 1'b1;

        for (int v = 0; v < 17; v++) begin
            cycle(tbl[v].en, tbl[v].ld, tbl[v].code);
            chk($sformatf("vec%0d", v), 64'({tick, cfg_busy, clk_out}),
                64'({tbl[v].tk, tbl[v].busy, tbl[v].clk}));
            $display("vec %0d en=%0b ld=%0b clk=%b busy=%0b tick=%b",
                     v, tbl[v].en, tbl[v].ld, clk_out, cfg_busy, tick);
        end

        // Enable dropped for 5 cycles in the first high phase stretches it from 2 to 7.
        do_reset();
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        chk("hold_rise", 64'(clk_out[0]), 64'(1));
        hi = 1;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b0, '0);
            chk("hold_tick", 64'(tick), 64'(0));
            if (clk_out[0]) hi++;
        end
        for (int k = 0; k < 20; k++) begin
            cycle(1'b1, 1'b0, '0);
            if (clk_out[0]) hi++;
            else break;
        end
        chk("hold_high_len", 64'(hi), 64'(7));
        $display("enable hold: high phase %0d cycles", hi);

        // Second load while busy must not replace the pending codes.
        cycle(1'b1, 1'b1, 16'h7310);
        chk("busy_set", 64'(cfg_busy), 64'(1));
        cycle(1'b1, 1'b1, 16'h2222);
        n = 0;
        while (cfg_busy && n < 100) begin
            cycle(1'b1, 1'b0, '0);
            n++;
        end
        chk("drain_done", 64'(cfg_busy), 64'(0));
        measure_period(3, p); chk("period_ch3", 64'(p), 64'(16));
        measure_period(2, p); chk("period_ch2", 64'(p), 64'(8));
        measure_period(0, p); chk("period_ch0", 64'(p), 64'(2));
        $display("busy ignore: drain %0d cycles, ch0 period %0d", n, p);

        // Reset during a drain discards the pending codes.
        cycle(1'b1, 1'b1, 16'hFFFF);
        cycle(1'b1, 1'b0, '0);
        chk("mid_drain_busy", 64'(cfg_busy), 64'(1));
        do_reset();
        measure_period(3, p); chk("post_rst_ch3", 64'(p), 64'(4));
        measure_period(0, p); chk("post_rst_ch0", 64'(p), 64'(4));
        $display("reset mid-drain: ch0 period %0d", p);

        for (int k = 0; k < 1500; k++) begin
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 24) == 0);
            rc = W'($urandom);
            if (ld && !cfg_busy) $display("random load code=%h at cycle %0d", rc, k);
            cycle(en, ld, rc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
